// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
package dram_pkg;

  localparam int unsigned DefAw = 10;
  localparam int unsigned DefDw = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StRdWait = 2'd2
  } state_e;

  localparam logic MCpu = 1'b0;
  localparam logic MDma = 1'b1;

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Request/response bundle for one master of the data-RAM arbiter.
interface dram_port_arbiter_if
  import dram_pkg::*;
#(
  parameter int unsigned AW = DefAw,
  parameter int unsigned DW = DefDw
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/dram_port_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie the master that did not own the port last wins.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       sel_o,
  output logic       any_o
);

  assign any_o = |req_i;
  assign sel_o = (req_i == 2'b11) ? ~last_i : req_i[1];

endmodule

// File: rtl/dram_port_arbiter.sv
// Serialises two masters onto the single-port data RAM and returns read data per master.
module dram_port_arbiter
  import dram_pkg::*;
#(
  parameter int unsigned AW     = DefAw,
  parameter int unsigned DW     = DefDw,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  dram_port_arbiter_if.slave m0_if,
  dram_port_arbiter_if.slave m1_if,
  output logic [AW-1:0]      ram_addr_o,
  output logic               ram_we_o,
  output logic [DW-1:0]      ram_din_o,
  input  logic [DW-1:0]      ram_dout_i,
  output logic               busy_o,
  output logic [CNT_W-1:0]   contend_cnt_o
);

  localparam logic [1:0] RdCntInit = 2'(RD_LAT - 1);

  state_e             state_q;
  logic               owner_q, last_q;
  logic [1:0]         rd_cnt_q;
  logic [AW-1:0]      ram_addr_q;
  logic               ram_we_q;
  logic [DW-1:0]      ram_din_q;
  logic [1:0]         gnt_q, rvalid_q;
  logic [DW-1:0]      rdata0_q, rdata1_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pick_sel, pick_any;

  rr_pick2 u_pick (
    .req_i  ({m1_if.req, m0_if.req}),
    .last_i (last_q),
    .sel_o  (pick_sel),
    .any_o  (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= MCpu;
      last_q     <= MDma;
      rd_cnt_q   <= '0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_din_q  <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      case (state_q)
        StIdle: begin
          if (pick_any) begin
            // Command and grant are registered here so both are visible during StIssue.
            owner_q    <= pick_sel;
            gnt_q      <= pick_sel ? 2'b10 : 2'b01;
            ram_addr_q <= pick_sel ? m1_if.addr  : m0_if.addr;
            ram_we_q   <= pick_sel ? m1_if.we    : m0_if.we;
            ram_din_q  <= pick_sel ? m1_if.wdata : m0_if.wdata;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          last_q   <= owner_q;
          ram_we_q <= 1'b0;
          if (ram_we_q) begin
            state_q <= StIdle;
          end else begin
            rd_cnt_q <= RdCntInit;
            state_q  <= StRdWait;
          end
        end
        StRdWait: begin
          if (rd_cnt_q == 2'd0) begin
            if (owner_q == MDma) begin
              rdata1_q    <= ram_dout_i;
              rvalid_q[1] <= 1'b1;
            end else begin
              rdata0_q    <= ram_dout_i;
              rvalid_q[0] <= 1'b1;
            end
            state_q <= StIdle;
          end else begin
            rd_cnt_q <= rd_cnt_q - 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Saturating count of cycles where both masters wait and nobody is being granted.
  always_comb begin
    cnt_d = cnt_q;
    if (m0_if.req && m1_if.req && (gnt_q == 2'b00) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign m0_if.gnt     = gnt_q[0];
  assign m1_if.gnt     = gnt_q[1];
  assign m0_if.rvalid  = rvalid_q[0];
  assign m1_if.rvalid  = rvalid_q[1];
  assign m0_if.rdata   = rdata0_q;
  assign m1_if.rdata   = rdata1_q;
  assign ram_addr_o    = ram_addr_q;
  assign ram_we_o      = ram_we_q;
  assign ram_din_o     = ram_din_q;
  assign busy_o        = (state_q != StIdle);
  assign contend_cnt_o = cnt_q;

endmodule
